frb_burst_detect: RTL
=====================

# frb_burst_detect

Consumer of the moving-average baseline in the FRB detection chain. Pairs each raw power sample with the baseline the moving average produces for it, subtracts the baseline, and compares the excess against a runtime threshold. Each contiguous above-threshold run becomes one event report giving peak excess, run width and peak sample index, with a hold-off window after each event. Output feeds the event readout logic.

## Interface
- DIN_WIDTH, 25: sample and baseline width, signed.
- DIN_POINT, 24: fractional bits of din, avg_in and thresh.
- FIFO_DEPTH, 16: sample alignment FIFO depth; must be a power of 2 and at least the moving-average latency in samples.
- WIDTH_BITS, 12: width of the run-width counter.
- HOLDOFF, 64: paired samples ignored after an event.
- clk, input, 1: the single clock.
- rst, input, 1: asynchronous, active-low reset.
- din, input, DIN_WIDTH: raw sample, signed.
- din_valid, input, 1: din qualifier.
- avg_in, input, DIN_WIDTH: baseline from the moving average, signed.
- avg_valid, input, 1: avg_in qualifier.
- thresh, input, DIN_WIDTH+1: excess threshold, signed, same point.
- det_valid, output, 1: one-cycle event pulse.
- det_peak, output, DIN_WIDTH+1: maximum excess in the run.
- det_width, output, WIDTH_BITS: run length in samples.
- det_index, output, 32: sample index of the peak.
- ovf, output, 1: sticky flag, FIFO overflow.
- unf, output, 1: sticky flag, FIFO underflow.

## Operation
- **Alignment FIFO**
  - din_valid pushes din.
  - avg_valid pops the head and pairs it with avg_in.
  - Push to a full FIFO without a pop: the sample is dropped and ovf is set.
  - avg_valid with the FIFO empty: the pair is discarded and unf is set. This holds even with a simultaneous push; the push is kept.
  - Simultaneous push and pop while full is legal; the count is unchanged.
- **Pair handling**
  - Each pair computes excess = sample − avg_in at DIN_WIDTH+1 bits (full precision, no overflow possible).
  - The 32-bit index counter increments once per pair and wraps at 2^32.
  - above = (excess > thresh), signed compare.
- **FSM** (advances only on pair cycles)
  - IDLE: when above, go to RUN. Set peak = excess, peak_idx = index, width = 1.
  - RUN: when above, width increments (saturates at 2^WIDTH_BITS−1), and peak and peak_idx update when excess > peak (strictly greater, so ties keep the first index). When not above, emit the event and go to HOLD with the counter set to HOLDOFF.
  - HOLD: decrement per pair. When the counter hits 0, go to IDLE. Pairs seen in HOLD are never evaluated, including the pair that takes the counter to 0. HOLDOFF=0 returns to IDLE on the next pair.
- thresh is read live on every compare, with no latching.
- **Reset**: FSM goes to IDLE; FIFO, counters, index, ovf and unf clear; all outputs are 0. A reset during RUN discards the run with no event.

## Timing
- Pop and pair at cycle t. excess is registered at t+1. The FSM and compare act at t+2.
- The terminating pair popped at t gives det_valid high at t+2 for exactly one cycle.
- det_peak, det_width and det_index are registered and hold their values until the next event.
- din_valid and avg_valid may be asserted every cycle; there is no backpressure.
- ovf and unf assert the cycle after the offending event and stay high until reset.

## Structure
- Package frb_det_pkg holds:
  - the state typedef (IDLE, RUN, HOLD);
  - the index width constant (32);
  - the excess width helper (DIN_WIDTH+1).
- Sub-module sync_fifo: single-clock, power-of-2 depth, full and empty outputs. Reusable elsewhere in the chain.

## Test plan
- **Single burst**: thresh=0.1, 3-sample lag, zero baseline, samples 0,0.2,0.5,0.3,0 at indices 10–14 → one det_valid with peak=0.5, width=3, index=12.
- **Hold-off**: HOLDOFF=4, second burst starting 2 pairs after the first event → no second event. The same burst starting 6 pairs after → reported.
- **Peak tie**: excess sequence 0.4,0.4 above thresh → index of the first 0.4.
- **FIFO faults**: 17 pushes with no pops at FIFO_DEPTH=16 → ovf=1, FIFO holds the first 16 samples. avg_valid into an empty FIFO → unf=1, no index increment.
- **Width saturation**: WIDTH_BITS=4, 20-sample run → det_width=15.
- **Reset mid-run**: assert rst during RUN → outputs are 0 and no det_valid. A fresh burst after release is reported with index restarting at 0.

Source files
------------

// File: rtl/frb_det_pkg.sv
// Shared types and constants for the FRB burst detector.
//   det_state_t  : detector FSM states
//   IDX_W        : width of the pair index counter
//   excess_width : width of sample - baseline at full precision
package frb_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } det_state_t;

  localparam int unsigned IDX_W = 32;

  // One extra bit holds the difference of two signed values without overflow.
  function automatic int unsigned excess_width(input int unsigned din_width);
    return din_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-2 depth and first-word-fall-through head.
//   clk, rst   : clock, asynchronous active-low reset
//   wr_en/data : push request; dropped when full unless a pop happens too
//   rd_en      : pop request; ignored when empty
//   rd_data_c  : current head word (combinational)
//   full/empty : registered occupancy flags
module sync_fifo #(
  parameter int unsigned WIDTH = 25,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo DEPTH must be a power of 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             wr_ok;
  logic             rd_ok;

  // A pop frees the head slot in the same cycle, so push-while-full is legal then.
  assign wr_ok     = wr_en && (!full || rd_en);
  assign rd_ok     = rd_en && !empty;
  assign count_nxt = count + CW'(wr_ok) - CW'(rd_ok);
  assign rd_data_c = mem[rd_ptr];

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/frb_burst_detect.sv
// Pairs raw samples with their moving-average baseline, thresholds the excess
// and reports each above-threshold run as one event followed by a hold-off.
//   clk, rst             : clock, asynchronous active-low reset
//   din/din_valid        : raw sample stream (pushed into alignment FIFO)
//   avg_in/avg_valid     : baseline stream (pops FIFO head to form a pair)
//   thresh               : live excess threshold
//   det_valid            : one-cycle event pulse
//   det_peak/width/index : peak excess, run length, peak pair index
//   ovf/unf              : sticky FIFO overflow / underflow
module frb_burst_detect
  import frb_det_pkg::*;
#(
  parameter int unsigned DIN_WIDTH  = 25,
  parameter int unsigned DIN_POINT  = 24,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned WIDTH_BITS = 12,
  parameter int unsigned HOLDOFF    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  din_valid,
  input  logic [DIN_WIDTH-1:0]  avg_in,
  input  logic                  avg_valid,
  input  logic [DIN_WIDTH:0]    thresh,
  output logic                  det_valid,
  output logic [DIN_WIDTH:0]    det_peak,
  output logic [WIDTH_BITS-1:0] det_width,
  output logic [IDX_W-1:0]      det_index,
  output logic                  ovf,
  output logic                  unf
);

  localparam int unsigned EW = excess_width(DIN_WIDTH);
  localparam int unsigned HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  if (DIN_POINT >= DIN_WIDTH) begin : g_bad_point
    $error("frb_burst_detect DIN_POINT must be below DIN_WIDTH");
  end

  logic [DIN_WIDTH-1:0]  head_c;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pair_c;
  logic                  pair_q;
  logic signed [EW-1:0]  excess_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      idx_cnt;
  logic                  above_c;

  det_state_t            state_q, state_d;
  logic signed [EW-1:0]  peak_q, peak_d;
  logic [IDX_W-1:0]      pidx_q, pidx_d;
  logic [WIDTH_BITS-1:0] width_q, width_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic                  det_valid_d;
  logic [EW-1:0]         det_peak_d;
  logic [WIDTH_BITS-1:0] det_width_d;
  logic [IDX_W-1:0]      det_index_d;

  sync_fifo #(
    .WIDTH (DIN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (din_valid),
    .wr_data   (din),
    .rd_en     (avg_valid),
    .rd_data_c (head_c),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A baseline arriving with nothing queued is discarded, not paired.
  assign pair_c = avg_valid && !fifo_empty;

  // Sticky fault flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (din_valid && fifo_full && !avg_valid) ovf <= 1'b1;
      if (avg_valid && fifo_empty)              unf <= 1'b1;
    end
  end

  // Pair stage: full-precision excess and the pair's index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair_q   <= 1'b0;
      excess_q <= '0;
      idx_q    <= '0;
      idx_cnt  <= '0;
    end else begin
      pair_q <= pair_c;
      if (pair_c) begin
        excess_q <= EW'($signed(head_c)) - EW'($signed(avg_in));
        idx_q    <= idx_cnt;
        idx_cnt  <= idx_cnt + IDX_W'(1);
      end
    end
  end

  assign above_c = excess_q > $signed(thresh);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state; only pair cycles advance it.
  always_comb begin
    state_d = state_q;
    if (pair_q) begin
      case (state_q)
        ST_IDLE: if (above_c)      state_d = ST_RUN;
        ST_RUN:  if (!above_c)     state_d = ST_HOLD;
        ST_HOLD: if (hold_q <= 1)  state_d = ST_IDLE;
        default:                   state_d = ST_IDLE;
      endcase
    end
  end

  // Run tracking and event outputs.
  always_comb begin
    peak_d      = peak_q;
    pidx_d      = pidx_q;
    width_d     = width_q;
    hold_d      = hold_q;
    det_valid_d = 1'b0;
    det_peak_d  = det_peak;
    det_width_d = det_width;
    det_index_d = det_index;
    if (pair_q) begin
      case (state_q)
        ST_IDLE: begin
          if (above_c) begin
            peak_d  = excess_q;
            pidx_d  = idx_q;
            width_d = WIDTH_BITS'(1);
          end
        end
        ST_RUN: begin
          if (above_c) begin
            if (width_q != '1) width_d = width_q + WIDTH_BITS'(1);
            // Strictly greater: ties keep the earliest index.
            if (excess_q > peak_q) begin
              peak_d = excess_q;
              pidx_d = idx_q;
            end
          end else begin
            det_valid_d = 1'b1;
            det_peak_d  = peak_q;
            det_width_d = width_q;
            det_index_d = pidx_q;
            hold_d      = HW'(HOLDOFF);
          end
        end
        ST_HOLD: begin
          if (hold_q != '0) hold_d = hold_q - HW'(1);
        end
        default: ;
      endcase
    end
  end

  // Run and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak_q    <= '0;
      pidx_q    <= '0;
      width_q   <= '0;
      hold_q    <= '0;
      det_valid <= 1'b0;
      det_peak  <= '0;
      det_width <= '0;
      det_index <= '0;
    end else begin
      peak_q    <= peak_d;
      pidx_q    <= pidx_d;
      width_q   <= width_d;
      hold_q    <= hold_d;
      det_valid <= det_valid_d;
      det_peak  <= det_peak_d;
      det_width <= det_width_d;
      det_index <= det_index_d;
    end
  end

endmodule
